// File: rtl/adder_if.sv
// adder_if: operand/result bundle for the pipelined binary32 adder.
interface adder_if;
   logic        in_valid;
   logic [31:0] operand_1;
   logic [31:0] operand_2;
   logic        out_valid;
   logic [31:0] result;
   logic        overflow;
   logic        invalid;
   modport master (output in_valid, operand_1, operand_2, input out_valid, result, overflow, invalid);
   modport slave  (input in_valid, operand_1, operand_2, output out_valid, result, overflow, invalid);
endinterface

// File: rtl/adder.sv
// adder: 3-stage pipelined binary32 adder (align, add, normalize/round-to-nearest-even).
// Define ADDER_SUBNORMAL_EN for gradual underflow; the default build flushes subnormals to zero.
module adder #(
   parameter int          LATENCY = 3,
   parameter logic [31:0] QNAN    = 32'h7FC0_0000
) (
   input logic    clk,
   input logic    rst,
   adder_if.slave s_if
);
   logic [31:0]        w_a, w_b, w_spv, w_res;
   logic               w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_swap, w_inv, w_sp;
   logic [7:0]         w_xa, w_xb, w_diff;
   logic [23:0]        w_ma, w_mb, w_msml, w_sig, w_man;
   logic [49:0]        w_tmp;
   logic [4:0]         w_lz, w_sh;
   logic [26:0]        w_norm;
   logic               w_cy, w_g, w_st, w_zero, w_ovf, w_uf, w_ovr;
   logic [24:0]        w_rnd;
   logic signed [8:0]  w_en, w_ef;
   logic [LATENCY-1:0] r_vld;
   logic               r_sp1, r_inv1, r_sgn1, r_sub1, r_sp2, r_inv2, r_sgn2, r_sub2;
   logic [31:0]        r_spv1, r_spv2, r_res;
   logic [7:0]         r_e1, r_e2;
   logic [26:0]        r_big1, r_sml1;
   logic [27:0]        r_sum2;
   logic               r_ovf, r_inv;
   assign w_a = s_if.operand_1;
   assign w_b = s_if.operand_2;
   always_comb begin
      w_nan_a = (&w_a[30:23]) & (|w_a[22:0]);
      w_nan_b = (&w_b[30:23]) & (|w_b[22:0]);
      w_inf_a = (&w_a[30:23]) & ~(|w_a[22:0]);
      w_inf_b = (&w_b[30:23]) & ~(|w_b[22:0]);
`ifdef ADDER_SUBNORMAL_EN
      w_xa = (|w_a[30:23]) ? w_a[30:23] : 8'd1;
      w_xb = (|w_b[30:23]) ? w_b[30:23] : 8'd1;
      w_ma = {|w_a[30:23], w_a[22:0]};
      w_mb = {|w_b[30:23], w_b[22:0]};
`else
      w_xa = w_a[30:23];
      w_xb = w_b[30:23];
      w_ma = (|w_a[30:23]) ? {1'b1, w_a[22:0]} : 24'd0;
      w_mb = (|w_b[30:23]) ? {1'b1, w_b[22:0]} : 24'd0;
`endif
      w_swap = {w_xb, w_mb} > {w_xa, w_ma};
      w_diff = w_swap ? w_xb - w_xa : w_xa - w_xb;
      w_msml = w_swap ? w_ma : w_mb;
      w_tmp  = {w_msml, 26'd0} >> w_diff;
      w_inv  = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (w_a[31] ^ w_b[31]));
      w_sp   = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
      w_spv  = w_inv ? QNAN : {w_inf_a ? w_a[31] : w_b[31], 8'hFF, 23'd0};
   end
   // data stages carry no reset; only the valid pipe and the outputs are cleared
   always_ff @(posedge clk) begin
      r_sp1  <= w_sp;
      r_inv1 <= w_inv;
      r_spv1 <= w_spv;
      r_sgn1 <= w_swap ? w_b[31] : w_a[31];
      r_sub1 <= w_a[31] ^ w_b[31];
      r_e1   <= w_swap ? w_xb : w_xa;
      r_big1 <= {w_swap ? w_mb : w_ma, 3'd0};
      r_sml1 <= (w_diff > 8'd26) ? {26'd0, |w_msml} : {w_tmp[49:24], |w_tmp[23:0]};
      r_sp2  <= r_sp1;
      r_inv2 <= r_inv1;
      r_spv2 <= r_spv1;
      r_sgn2 <= r_sgn1;
      r_sub2 <= r_sub1;
      r_e2   <= r_e1;
      r_sum2 <= r_sub1 ? {1'b0, r_big1} - {1'b0, r_sml1} : {1'b0, r_big1} + {1'b0, r_sml1};
   end
   always_comb begin
      w_lz = 5'd27;
      for (int i = 0; i < 27; i++) if (r_sum2[i]) w_lz = 5'(26 - i);
`ifdef ADDER_SUBNORMAL_EN
      w_sh = ({3'd0, w_lz} < r_e2 - 8'd1) ? w_lz : 5'(r_e2 - 8'd1);
`else
      w_sh = w_lz;
`endif
      w_norm = r_sum2[26:0] << w_sh;
      w_cy   = r_sum2[27];
      w_sig  = w_cy ? r_sum2[27:4] : w_norm[26:3];
      w_g    = w_cy ? r_sum2[3] : w_norm[2];
      w_st   = w_cy ? |r_sum2[2:0] : |w_norm[1:0];
      w_en   = w_cy ? $signed({1'b0, r_e2}) + 9'sd1 : $signed({1'b0, r_e2}) - $signed({4'd0, w_sh});
      w_rnd  = {1'b0, w_sig} + {24'd0, w_g & (w_st | w_sig[0])};
      w_ef   = w_en + $signed({8'd0, w_rnd[24]});
      w_man  = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];
      // w_en tops out at 255, so the 9-bit sum can only wrap once that is already flagged
      w_ovf  = (w_en == 9'sd255) || (w_ef == 9'sd255);
      w_zero = ~(|r_sum2);
`ifdef ADDER_SUBNORMAL_EN
      w_uf   = 1'b0;
`else
      w_uf   = w_ef <= 9'sd0;
`endif
      w_ovr  = ~r_sp2 & ~w_zero & w_ovf;
      w_res  = r_sp2  ? r_spv2 :
               w_zero ? {~r_sub2 & r_sgn2, 31'd0} :
               w_ovf  ? {r_sgn2, 8'hFF, 23'd0} :
               w_uf   ? {r_sgn2, 31'd0} :
                        {r_sgn2, w_man[23] ? w_ef[7:0] : 8'd0, w_man[22:0]};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         r_res <= '0;
         r_ovf <= 1'b0;
         r_inv <= 1'b0;
      end else begin
         r_vld <= {r_vld[LATENCY-2:0], s_if.in_valid};
         if (r_vld[LATENCY-2]) begin
            r_res <= w_res;
            r_ovf <= w_ovr;
            r_inv <= r_inv2;
         end
      end
   end
   assign s_if.out_valid = r_vld[LATENCY-1];
   assign s_if.result    = r_res;
   assign s_if.overflow  = r_ovf;
   assign s_if.invalid   = r_inv;
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for adder; expected sums come from an exact wide-integer model.
module tb_adder;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef ADDER_SUBNORMAL_EN
   localparam logic [31:0] SUBR = 32'h0000_0012;
`else
   localparam logic [31:0] SUBR = 32'h0000_0000;
`endif
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [33:0] e;
      logic [31:0] due;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs = 0, checks = 0, cyc = 0, n_out = 0;
   exp_t q[$];
   adder_if u_if ();
   adder u_dut (.clk(clk), .rst(rst), .s_if(u_if));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [279:0] mag(input logic [31:0] x);
`ifdef ADDER_SUBNORMAL_EN
      return (|x[30:23]) ? (280'({1'b1, x[22:0]}) << (x[30:23] - 8'd1)) : 280'(x[22:0]);
`else
      return (|x[30:23]) ? (280'({1'b1, x[22:0]}) << (x[30:23] - 8'd1)) : 280'd0;
`endif
   endfunction
   // exact sum in units of 2^-149, then rounded once to 24 bits; returns {invalid, overflow, result}
   function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      logic [279:0] ma, mb, s, qv, rem, half, one;
      logic na, nb, ia, ib, neg;
      int p, sh;
      na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      if (na || nb || (ia && ib && a[31] != b[31])) return {2'b10, QNAN};
      if (ia) return {2'b00, a};
      if (ib) return {2'b00, b};
      ma = mag(a);
      mb = mag(b);
      if (a[31] == b[31]) begin s = ma + mb; neg = a[31]; end
      else if (ma >= mb) begin s = ma - mb; neg = a[31]; end
      else begin s = mb - ma; neg = b[31]; end
      if (s == 0) return {2'b00, a[31] & b[31], 31'd0};
      p = 0;
      for (int i = 0; i < 280; i++) if (s[i]) p = i;
`ifdef ADDER_SUBNORMAL_EN
      if (p < 23) return {2'b00, neg, s[30:0]};
`else
      if (p < 23) return {2'b00, neg, 31'd0};
`endif
      sh = p - 23;
      one = 280'd1;
      qv = s >> sh;
      rem = s & ((one << sh) - one);
      half = (one << sh) >> 1;
      if (sh > 0 && (rem > half || (rem == half && qv[0]))) qv = qv + one;
      if (qv[24]) begin qv = qv >> 1; p++; end
      if (p - 22 >= 255) return {2'b01, neg, 8'hFF, 23'd0};
      return {2'b00, neg, 8'(p - 22), qv[22:0]};
   endfunction
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [33:0] e);
      @(negedge clk);
      u_if.in_valid  = 1'b1;
      u_if.operand_1 = a;
      u_if.operand_2 = b;
      q.push_back('{a: a, b: b, e: e, due: 32'(cyc + 3)});
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         u_if.in_valid = 1'b0;
         u_if.operand_1 = $urandom;
         u_if.operand_2 = $urandom;
      end
   endtask
   always @(negedge clk) begin
      if (!rst && u_if.out_valid) begin
         exp_t e;
         n_out++;
         checks++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_out result=%h ov=%b inv=%b at cycle %0d", u_if.result, u_if.overflow, u_if.invalid, cyc);
         end else begin
            e = q.pop_front();
            if ({u_if.invalid, u_if.overflow, u_if.result} !== e.e) begin
               errs++;
               $display("FAIL sum a=%h b=%h got result=%h ov=%b inv=%b want result=%h ov=%b inv=%b",
                        e.a, e.b, u_if.result, u_if.overflow, u_if.invalid, e.e[31:0], e.e[32], e.e[33]);
            end
            checks++;
            if (cyc != int'(e.due)) begin
               errs++;
               $display("FAIL latency a=%h b=%h got cycle %0d want cycle %0d", e.a, e.b, cyc, e.due);
            end
         end
      end
   end
   initial begin
      logic [31:0] dv_a [11];
      logic [31:0] dv_b [11];
      logic [33:0] dv_e [11];
      logic [31:0] a, b;
      logic [31:0] sp [8];
      int base;
      dv_a = '{32'h1000_0010, 32'h1000_0010, 32'h3F80_0000, 32'h0000_0010, 32'h3F80_0000, 32'h3F80_0000,
               32'h3F80_0001, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h7FC0_1234, 32'h8000_0000};
      dv_b = '{32'h0000_0002, 32'h1000_0002, 32'h3F80_0000, 32'h0000_0002, 32'hBF80_0000, 32'h3380_0000,
               32'h3380_0000, 32'hFF80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h8000_0000};
      dv_e = '{{2'b00, 32'h1000_0010}, {2'b00, 32'h1080_0009}, {2'b00, 32'h4000_0000}, {2'b00, SUBR},
               {2'b00, 32'h0000_0000}, {2'b00, 32'h3F80_0000}, {2'b00, 32'h3F80_0002}, {2'b10, QNAN},
               {2'b01, 32'h7F80_0000}, {2'b10, QNAN}, {2'b00, 32'h8000_0000}};
      sp = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0000, 32'h8000_0000,
             32'h0000_1234, 32'h7F7F_FFFF, 32'h0080_0000};
      u_if.in_valid = 1'b0;
      u_if.operand_1 = '0;
      u_if.operand_2 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({u_if.out_valid, u_if.result, u_if.overflow, u_if.invalid} !== 35'd0) begin
         errs++;
         $display("FAIL reset_state got valid=%b result=%h ov=%b inv=%b want all zero",
                  u_if.out_valid, u_if.result, u_if.overflow, u_if.invalid);
      end
      rst = 1'b0;
      issue(dv_a[0], dv_b[0], dv_e[0]);
      idle(5);
      for (int i = 1; i < 11; i++) issue(dv_a[i], dv_b[i], dv_e[i]);
      idle(2);
      for (int i = 0; i < 600; i++) begin
         int m;
         a = $urandom;
         b = $urandom;
         m = $urandom_range(0, 4);
         if (m == 1) b = {b[31], a[30:23] ^ 8'($urandom_range(0, 1)), b[22:0]};
         if (m == 2) begin
            a[30:23] = 8'($urandom_range(100, 160));
            b[30:23] = 8'(int'(a[30:23]) - 30 + $urandom_range(0, 60));
         end
         if (m == 3) a = sp[$urandom_range(0, 7)];
         if (m == 4) b = $urandom_range(0, 1) ? {~a[31], a[30:0]} : a;
         if ($urandom_range(0, 3) == 0) idle(1);
         else issue(a, b, ref_add(a, b));
      end
      for (int i = 0; i < 5; i++) begin
         a = $urandom;
         b = {a[31], a[30:23] - 8'd1, b[22:0]};
         issue(a, b, ref_add(a, b));
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      u_if.in_valid = 1'b0;
      #1;
      checks++;
      if (u_if.out_valid !== 1'b0) begin
         errs++;
         $display("FAIL async_reset out_valid got %b want 0", u_if.out_valid);
      end
      q.delete();
      base = n_out;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(8);
      checks++;
      if (n_out != base) begin
         errs++;
         $display("FAIL stale_after_reset got %0d outputs want 0", n_out - base);
      end
      for (int i = 0; i < 5; i++) issue(dv_a[i + 4], dv_b[i + 4], dv_e[i + 4]);
      idle(1);
      for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/adder.md
Name: adder

Overview:
- Pipelined IEEE-754 single-precision floating-point adder for the neural-network datapath (neuron accumulation).
- Computes result = operand_1 + operand_2.
- Fully pipelined, no back-pressure: accepts one operation per clock and delivers it a fixed 3 cycles later.

Parameters:
- LATENCY, 3, pipeline depth in cycles. Fixed; documented for integrators only; any other value unsupported.
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for every NaN result.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid this cycle.
- operand_1  input  32  IEEE-754 binary32 addend A.
- operand_2  input  32  IEEE-754 binary32 addend B.
- out_valid  output  1  result valid this cycle.
- result  output  32  binary32 sum.
- overflow  output  1  finite inputs produced ±Inf; qualified by out_valid.
- invalid  output  1  NaN produced (NaN input or +Inf + -Inf); qualified by out_valid.

Behaviour:
- Reset: while rst is high, all pipeline valid bits, out_valid, result, overflow and invalid are 0, asynchronously. In-flight operations are discarded. First accept happens on the first rising edge after rst deasserts.
- Pipeline stage 1 (align):
  - Unpack both operands and classify each as zero, subnormal, normal, Inf or NaN.
  - Swap so the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference.
  - Keep guard and round bits; OR all further shifted-out bits into sticky.
  - Shifts ≥ 27 leave only sticky.
- Pipeline stage 2 (add): add significands if signs are equal, otherwise subtract (larger − smaller) with a 25-bit result plus G/R/S.
- Pipeline stage 3 (normalize/round):
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise count leading zeros and shift left, limited by the exponent.
  - Round to nearest, ties to even.
  - Re-normalize on rounding carry.
  - Pack the result.
- Timing: in_valid at edge N gives out_valid at edge N+3. Back-to-back inputs give back-to-back outputs. When out_valid is 0, result and the flags hold their last values.
- Special cases, in priority order:
  - Any NaN input: result QNAN, invalid = 1.
  - +Inf + -Inf: result QNAN, invalid = 1.
  - One Inf input: that Inf.
  - Both zero: +0, unless both are -0, which gives -0.
  - Exact cancellation of nonzero values: +0.
- Overflow: if the rounded exponent is ≥ 255, result is ±Inf with the sign of the sum and overflow = 1.
- Subnormals: handled as defined under Optional Feature.
- Width rule: internal significand datapath is 24 bits (hidden bit included) + 1 carry + 3 G/R/S bits. The exponent datapath is 9 bits signed to detect overflow/underflow.

Optional Feature:
- Macro: ADDER_SUBNORMAL_EN.
- Defined:
  - Full gradual underflow.
  - Subnormal inputs use exponent 1 with hidden bit 0.
  - Results below the minimum normal are emitted as correctly rounded subnormals.
  - Normalization left-shift stops at exponent 1.
- Undefined (default): flush-to-zero.
  - Any subnormal input is treated as a zero of the same sign.
  - Any result whose rounded magnitude is below 2^-126 becomes a zero carrying the sum's sign, except exact cancellation, which yields +0.
  - Saves the subnormal shifter logic.

Test Plan:
- Build without ADDER_SUBNORMAL_EN. Drive 32'h1000_0010 + 32'h0000_0002 with in_valid for one cycle. Expect out_valid 3 cycles later, result 32'h1000_0010, flags 0.
- Same exponent, carry-out: 32'h1000_0010 + 32'h1000_0002 → 32'h1080_0009. Also 32'h3F80_0000 + 32'h3F80_0000 → 32'h4000_0000.
- Subnormal pair 32'h0000_0010 + 32'h0000_0002:
  - Without macro → 32'h0000_0000.
  - With ADDER_SUBNORMAL_EN → 32'h0000_0012.
  - With the macro, 32'h1000_0010 + 32'h0000_0002 still → 32'h1000_0010 (sticky only, rounds down).
- Cancellation and rounding:
  - 32'h3F80_0000 + 32'hBF80_0000 → 32'h0000_0000.
  - 32'h3F80_0000 + 32'h3380_0000 (1 + 2^-24, tie) → 32'h3F80_0000 (ties-to-even).
  - 32'h3F80_0001 + 32'h3380_0000 → 32'h3F80_0002.
- Specials:
  - 32'h7F80_0000 + 32'hFF80_0000 → 32'h7FC0_0000, invalid = 1.
  - 32'h7F7F_FFFF + 32'h7F7F_FFFF → 32'h7F80_0000, overflow = 1.
  - 32'h7FC0_1234 + 32'h3F80_0000 → 32'h7FC0_0000, invalid = 1.
- Streaming and reset:
  - Issue 5 consecutive valid operations; expect 5 consecutive out_valid cycles in order.
  - Assert rst asynchronously mid-stream; out_valid drops immediately, and no stale results appear after release.
